rf_param: RTL and testbench

- Parametrised successor to the fixed 8x16 register file in the unpipelined datapath.
- Data width and depth are set by parameters.
- Two combinational read ports and one synchronous write port.
- Adds a hardware clear sequencer that zeroes every entry, one per cycle, under a busy/err handshake, so control logic can flush the architectural state without a global reset.

---
 rtl/rf_param.sv | 97 +++++++++
 tb/tb_rf_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rf_param.sv
// Parametrised two-read/one-write register file with a clear sweep.
// Optional write-through forwarding enabled by defining RF_BYPASS_EN.
module rf_param #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [ADDR_W-1:0] writeregsel,
   input  logic [DATA_W-1:0] writedata,
   input  logic [ADDR_W-1:0] read1regsel,
   input  logic [ADDR_W-1:0] read2regsel,
   output logic [DATA_W-1:0] read1data,
   output logic [DATA_W-1:0] read2data,
   input  logic              clr,
   output logic              busy,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic clr_go;
   logic wr_go;
   logic wr_drop;
   logic last;

   // clr wins over a same-cycle write; anything not accepted is dropped
   assign clr_go  = (state == IDLE) && clr;
   assign wr_go   = (state == IDLE) && write && !clr;
   assign wr_drop = write && !wr_go;
   assign last    = (cnt == ADDR_W'(DEPTH - 1));

   // array, sweep FSM and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         err <= wr_drop;
         unique case (state)
            IDLE: begin
               if (clr_go) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else if (wr_go) begin
                  mem[writeregsel] <= writedata;
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               cnt      <= cnt + 1'b1;
               if (last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RF_BYPASS_EN
   logic fwd;

   // forward only writes that will actually land this edge
   assign fwd = wr_go;

   assign read1data = (fwd && (read1regsel == writeregsel)) ?
                      writedata : mem[read1regsel];
   assign read2data = (fwd && (read2regsel == writeregsel)) ?
                      writedata : mem[read2regsel];
`else
   // reads always reflect stored contents
   assign read1data = mem[read1regsel];
   assign read2data = mem[read2regsel];
`endif

endmodule

// File: tb/tb_rf_param.sv
// Randomised and directed bench for rf_param.
// Reference model: plain array plus a sweep position counter.
module tb_rf_param;

   logic        clk;
   logic        rst_n;
   logic        write;
   logic [2:0]  writeregsel;
   logic [15:0] writedata;
   logic [2:0]  read1regsel;
   logic [2:0]  read2regsel;
   logic [15:0] read1data;
   logic [15:0] read2data;
   logic        clr;
   logic        busy;
   logic        err;

   int tests;
   int fails;

   logic [15:0] model [8];
   int          sweep_left;
   int          sweep_idx;
   logic        err_m;
   int          nbusy;

   rf_param #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .write(write),
      .writeregsel(writeregsel),
      .writedata(writedata),
      .read1regsel(read1regsel),
      .read2regsel(read2regsel),
      .read1data(read1data),
      .read2data(read2data),
      .clr(clr),
      .busy(busy),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_rd(input logic [2:0] sel);
`ifdef RF_BYPASS_EN
      if (write && sweep_left == 0 && !clr && sel == writeregsel)
         return writedata;
`endif
      return model[sel];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) model[i] = 16'h0;
      sweep_left = 0;
      sweep_idx  = 0;
      err_m      = 1'b0;
   endtask

   // apply edge semantics to the model using current inputs
   task automatic model_edge();
      if (sweep_left > 0) begin
         model[sweep_idx] = 16'h0;
         sweep_idx++;
         sweep_left--;
         err_m = write;
      end else if (clr) begin
         sweep_left = 8;
         sweep_idx  = 0;
         err_m      = write;
      end else begin
         if (write) model[writeregsel] = writedata;
         err_m = 1'b0;
      end
   endtask

   // one clock: drive, check reads, clock, check handshake
   task automatic cyc(input logic w, input logic [2:0] ws,
                      input logic [15:0] wd, input logic c,
                      input logic [2:0] r1, input logic [2:0] r2);
      write       = w;
      writeregsel = ws;
      writedata   = wd;
      clr         = c;
      read1regsel = r1;
      read2regsel = r2;
      #1;
      chk("rd1", {16'h0, read1data}, {16'h0, exp_rd(r1)});
      chk("rd2", {16'h0, read2data}, {16'h0, exp_rd(r2)});
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", {31'h0, busy}, {31'h0, (sweep_left > 0)});
      chk("err", {31'h0, err}, {31'h0, err_m});
      if (busy) nbusy++;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      nbusy = 0;
      rst_n = 1'b0;
      write = 1'b0;
      clr = 1'b0;
      writeregsel = '0;
      writedata = '0;
      read1regsel = '0;
      read2regsel = '0;
      model_reset();
      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset contents on both ports
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'(7 - i));

      // basic writes, same-cycle read of r3
      cyc(1'b1, 3'd3, 16'hA5A5, 1'b0, 3'd3, 3'd7);
      cyc(1'b1, 3'd7, 16'h1234, 1'b0, 3'd3, 3'd7);
      cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd7);
      chk("r3", {16'h0, read1data}, 32'hA5A5);
      chk("r7", {16'h0, read2data}, 32'h1234);

      // fill, then sweep with a dropped write of r2
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 1'b0, 3'(i), 3'd4);
      nbusy = 0;
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd4);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) begin
            read1regsel = 3'd3;
            read2regsel = 3'd4;
            #1;
            chk("mid_r3", {16'h0, read1data}, 32'h0);
            chk("mid_r4", {16'h0, read2data}, 32'h5555);
         end
         cyc(k == 2, 3'd2, 16'hBEEF, 1'b0, 3'(k), 3'd4);
      end
      chk("busy_len1", nbusy, 32'd8);
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 3'd2);

      // clr with simultaneous write, second clr mid-sweep
      cyc(1'b1, 3'd5, 16'h7777, 1'b0, 3'd5, 3'd1);
      nbusy = 0;
      cyc(1'b1, 3'd1, 16'h00FF, 1'b1, 3'd1, 3'd5);
      for (int k = 0; k < 10; k++)
         cyc(1'b0, 3'd0, 16'h0, k == 3, 3'd1, 3'd5);
      chk("busy_len2", nbusy, 32'd8);

      // asynchronous reset partway through a sweep
      cyc(1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd6, 3'd6);
      cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd6);
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 3'd7);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_err", {31'h0, err}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         read1regsel = 3'(2 * i);
         read2regsel = 3'(2 * i + 1);
         #1;
         chk("arst_rd1", {16'h0, read1data}, 32'h0);
         chk("arst_rd2", {16'h0, read2data}, 32'h0);
      end
      rst_n = 1'b1;
      cyc(1'b1, 3'd5, 16'h0F0F, 1'b0, 3'd5, 3'd6);
      cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd5, 3'd6);
      chk("r5", {16'h0, read1data}, 32'h0F0F);

      // random traffic
      for (int n = 0; n < 400; n++)
         cyc($urandom_range(0, 2) != 0, 3'($urandom),
             16'($urandom), $urandom_range(0, 24) == 0,
             3'($urandom), 3'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
